// File: rtl/payload_extractor.sv
// Payload extractor: follows the header parser on a shared byte stream and,
// once the type/length field is accepted, forwards the payload bytes with a
// fixed one-cycle latency, flags the final byte, and counts completed frames.
// A type/length field in 1..1500 gives the payload length directly; a type
// field (>= 16'h0600) uses TYPE_PAYLOAD_LEN; anything else is a length error.
module payload_extractor #(
  parameter int TYPE_PAYLOAD_LEN = 46
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  data,
  input  logic        type_length_valid,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        payload_abort,
  output logic        length_error,
  output logic [15:0] payload_type,
  output logic [10:0] payload_len,
  output logic [15:0] frame_count
);

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam logic [10:0] TYPE_LEN = 11'(TYPE_PAYLOAD_LEN);

  state_t      state_q, state_d;
  logic [15:0] hist_q, hist_d;
  logic        tlv_prev_q, tlv_prev_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        pvalid_q, pvalid_d;
  logic        plast_q, plast_d;
  logic        pabort_q, pabort_d;
  logic        lerr_q, lerr_d;
  logic [15:0] ptype_q, ptype_d;
  logic [10:0] plen_q, plen_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        start;
  logic [10:0] start_len;

  // Frame counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Field interpreted as an explicit byte length.
  function automatic logic field_is_len(input logic [15:0] f);
    return (f != 16'd0) && (f <= 16'd1500);
  endfunction

  // Field interpreted as an EtherType.
  function automatic logic field_is_type(input logic [15:0] f);
    return f >= 16'h0600;
  endfunction

  // A start is the rising edge of type_length_valid seen on enabled cycles.
  assign start = enable && type_length_valid && !tlv_prev_q && (state_q == IDLE);

  // Next-state and next-output computation for the whole extractor.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    tlv_prev_d = tlv_prev_q;
    cnt_d      = cnt_q;
    pdata_d    = pdata_q;
    pvalid_d   = 1'b0;
    plast_d    = 1'b0;
    pabort_d   = 1'b0;
    lerr_d     = 1'b0;
    ptype_d    = ptype_q;
    plen_d     = plen_q;
    fcnt_d     = fcnt_q;
    start_len  = field_is_len(hist_q) ? hist_q[10:0] : TYPE_LEN;

    if (enable) begin
      hist_d     = {hist_q[7:0], data};
      tlv_prev_d = type_length_valid;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (field_is_len(hist_q) || field_is_type(hist_q)) begin
            // The byte arriving with the strobe is already payload byte 1.
            ptype_d  = hist_q;
            plen_d   = start_len;
            pdata_d  = data;
            pvalid_d = 1'b1;
            cnt_d    = 11'd1;
            if (start_len == 11'd1) begin
              plast_d = 1'b1;
              fcnt_d  = sat_inc16(fcnt_q);
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            lerr_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (enable) begin
          pdata_d  = data;
          pvalid_d = 1'b1;
          cnt_d    = cnt_q + 11'd1;
          if (cnt_d == plen_q) begin
            plast_d = 1'b1;
            fcnt_d  = sat_inc16(fcnt_q);
            state_d = IDLE;
          end
        end else begin
          // A stall mid-payload means the frame is lost.
          pabort_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything and wins over enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hist_q     <= 16'd0;
      tlv_prev_q <= 1'b0;
      cnt_q      <= 11'd0;
      pdata_q    <= 8'd0;
      pvalid_q   <= 1'b0;
      plast_q    <= 1'b0;
      pabort_q   <= 1'b0;
      lerr_q     <= 1'b0;
      ptype_q    <= 16'd0;
      plen_q     <= 11'd0;
      fcnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      tlv_prev_q <= tlv_prev_d;
      cnt_q      <= cnt_d;
      pdata_q    <= pdata_d;
      pvalid_q   <= pvalid_d;
      plast_q    <= plast_d;
      pabort_q   <= pabort_d;
      lerr_q     <= lerr_d;
      ptype_q    <= ptype_d;
      plen_q     <= plen_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign payload_data  = pdata_q;
  assign payload_valid = pvalid_q;
  assign payload_last  = plast_q;
  assign payload_abort = pabort_q;
  assign length_error  = lerr_q;
  assign payload_type  = ptype_q;
  assign payload_len   = plen_q;
  assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_payload_extractor.sv
// Scoreboard bench for payload_extractor: stimulus queues the expected
// output events, a negedge monitor pops and compares them as they appear.
module tb_payload_extractor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  data;
  logic        type_length_valid;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic        payload_abort;
  logic        length_error;
  logic [15:0] payload_type;
  logic [10:0] payload_len;
  logic [15:0] frame_count;

  // Event encoding: {valid, last, abort, length_error, data}
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  logic [11:0] mon_got;
  int checks = 0;
  int errors = 0;

  localparam logic [11:0] EV_ABORT = 12'h200;
  localparam logic [11:0] EV_LERR  = 12'h100;

  payload_extractor #(.TYPE_PAYLOAD_LEN(46)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .data              (data),
    .type_length_valid (type_length_valid),
    .payload_data      (payload_data),
    .payload_valid     (payload_valid),
    .payload_last      (payload_last),
    .payload_abort     (payload_abort),
    .length_error      (length_error),
    .payload_type      (payload_type),
    .payload_len       (payload_len),
    .frame_count       (frame_count)
  );

  always #5 clock = ~clock;

  // Monitor: every cycle with any output event must match the queue head.
  always @(negedge clock) begin
    if (payload_valid || payload_last || payload_abort || length_error) begin
      checks++;
      mon_got = {payload_valid, payload_last, payload_abort, length_error,
                 payload_valid ? payload_data : 8'h00};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %03h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL event: got %03h required %03h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [7:0] d, input logic tlv);
    enable            = en;
    data              = d;
    type_length_valid = tlv;
    @(posedge clock);
    #1;
  endtask

  task automatic push_data(input logic [7:0] d, input logic last);
    exp_q.push_back({1'b1, last, 2'b00, d});
  endtask

  task automatic header(input logic [15:0] field);
    cyc(1'b1, field[15:8], 1'b0);
    cyc(1'b1, field[7:0], 1'b0);
  endtask

  // Send header plus nsend payload bytes; len is the hand-derived length.
  task automatic frame(input logic [15:0] field, input int len, input int nsend,
                       input logic [7:0] seed, input logic hold_tlv);
    logic [7:0] d;
    header(field);
    for (int i = 0; i < nsend; i++) begin
      d = seed + 8'(i);
      push_data(d, (i + 1) == len);
      cyc(1'b1, d, (i == 0) || hold_tlv);
    end
  endtask

  task automatic bad_field(input logic [15:0] field);
    header(field);
    exp_q.push_back(EV_LERR);
    cyc(1'b1, 8'h55, 1'b1);
    cyc(1'b1, 8'h56, 1'b0);
    cyc(1'b1, 8'h57, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(payload_data), 32'h0);
    chk({tag, "_flags"}, 32'({payload_valid, payload_last, payload_abort, length_error}), 32'h0);
    chk({tag, "_type"},  32'(payload_type), 32'h0);
    chk({tag, "_len"},   32'(payload_len), 32'h0);
    chk({tag, "_fcnt"},  32'(frame_count), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    data = 8'h00;
    type_length_valid = 1'b0;
    cyc(1'b1, 8'h12, 1'b1);
    cyc(1'b1, 8'h34, 1'b0);
    chk_all_zero("reset");
    reset_n = 1'b1;
    cyc(1'b1, 8'h00, 1'b0);

    // Length 3 with a disabled cycle between field bytes (history must hold).
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b1, 8'h03, 1'b0);
    push_data(8'hAA, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1);
    push_data(8'hBB, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    push_data(8'hCC, 1'b1);
    cyc(1'b1, 8'hCC, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0);
    chk("len3_fcnt", 32'(frame_count), 32'd1);
    chk("len3_len",  32'(payload_len), 32'd3);
    chk("len3_type", 32'(payload_type), 32'h0003);

    // Type field: 46 bytes, strobe held high through payload (ignored).
    frame(16'h0800, 46, 46, 8'h10, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);
    chk("type_fcnt", 32'(frame_count), 32'd2);
    chk("type_len",  32'(payload_len), 32'd46);
    chk("type_type", 32'(payload_type), 32'h0800);

    // Illegal fields: no payload, counters and latched fields unchanged.
    bad_field(16'h05E0);
    bad_field(16'h0000);
    bad_field(16'h05DD);
    bad_field(16'h05FF);
    chk("lerr_fcnt", 32'(frame_count), 32'd2);
    chk("lerr_len",  32'(payload_len), 32'd46);
    chk("lerr_type", 32'(payload_type), 32'h0800);

    // Boundary legal fields: 1500 explicit and 0x0600 as type.
    frame(16'h05DC, 1500, 1500, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("l1500_len", 32'(payload_len), 32'd1500);
    frame(16'h0600, 46, 46, 8'h80, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("t600_fcnt", 32'(frame_count), 32'd4);

    // Abort after 5 of 16 bytes.
    frame(16'h0010, 16, 5, 8'h40, 1'b0);
    exp_q.push_back(EV_ABORT);
    cyc(1'b0, 8'hEE, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("abort_fcnt", 32'(frame_count), 32'd4);

    // Length 1, then a new strobe rise three cycles later (field 0x0002).
    header(16'h0001);
    push_data(8'h77, 1'b1);
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    push_data(8'h91, 1'b0);
    cyc(1'b1, 8'h91, 1'b1);
    push_data(8'h92, 1'b1);
    cyc(1'b1, 8'h92, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("len1_fcnt", 32'(frame_count), 32'd6);
    chk("len1_len",  32'(payload_len), 32'd2);

    // Saturation: preload the counter near the top.
    force dut.fcnt_q = 16'hFFFE;
    #1;
    release dut.fcnt_q;
    cyc(1'b1, 8'h00, 1'b0);
    frame(16'h0001, 1, 1, 8'hC0, 1'b0);
    chk("sat_fcnt1", 32'(frame_count), 32'hFFFF);
    frame(16'h0001, 1, 1, 8'hC1, 1'b0);
    chk("sat_fcnt2", 32'(frame_count), 32'hFFFF);

    // Reset mid-payload: outputs cleared, no abort/last.
    frame(16'h0010, 16, 3, 8'hD0, 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, 8'h11, 1'b0);
    chk_all_zero("midrst");
    reset_n = 1'b1;
    cyc(1'b1, 8'h00, 1'b0);
    frame(16'h0003, 3, 3, 8'hE0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("post_rst_fcnt", 32'(frame_count), 32'd1);

    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
